// File: rtl/sprite_motion.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_motion
//  Description : Bouncing sprite position generator. Once every FRAME_DIV
//                frames the sprite moves SPEED pixels on each axis. It is
//                clamped at the screen edges, where its direction reverses.
//                X is updated one cycle after the accepted frame pulse and
//                Y one cycle after that. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion #(
    parameter int CORDW     = 16,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int SPR_W     = 128,
    parameter int SPR_H     = 128,
    parameter int SPEED     = 1,
    parameter int FRAME_DIV = 1,
    parameter int X_INIT    = 32,
    parameter int Y_INIT    = 16
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    frame,
    input  logic                    pause,
    output logic signed [CORDW-1:0] sprx,
    output logic signed [CORDW-1:0] spry,
    output logic                    dir_x,
    output logic                    dir_y,
    output logic                    bounce_x,
    output logic                    bounce_y,
    output logic                    busy
);

    // Divider counter width; a single bit is kept even when FRAME_DIV is 1.
    localparam int C_CNTW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    // Limits and step in CORDW+1 signed bits so the next-position sum
    // can never wrap before it is compared against the limits.
    localparam logic signed [CORDW:0] c_xmax  = $signed((CORDW+1)'(H_RES - SPR_W));
    localparam logic signed [CORDW:0] c_ymax  = $signed((CORDW+1)'(V_RES - SPR_H));
    localparam logic signed [CORDW:0] c_speed = $signed((CORDW+1)'(SPEED));
    localparam logic signed [CORDW:0] c_zero  = '0;
    localparam logic [C_CNTW-1:0]     c_div_last = C_CNTW'(FRAME_DIV - 1);
    localparam logic signed [CORDW-1:0] c_x_init = $signed(CORDW'(X_INIT));
    localparam logic signed [CORDW-1:0] c_y_init = $signed(CORDW'(Y_INIT));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_X = 2'd1,
        MOVE_Y = 2'd2
    } state_t;

    state_t                  r_state;
    logic [C_CNTW-1:0]       r_count;
    logic signed [CORDW-1:0] r_sprx;
    logic signed [CORDW-1:0] r_spry;
    logic                    r_dir_x;
    logic                    r_dir_y;
    logic                    r_bounce_x;
    logic                    r_bounce_y;
    logic                    r_busy;

    logic signed [CORDW:0]   w_nx;
    logic signed [CORDW:0]   w_ny;

    // Candidate next positions, one step along the current direction.
    always_comb begin
        w_nx = r_dir_x ? ({r_sprx[CORDW-1], r_sprx} + c_speed)
                       : ({r_sprx[CORDW-1], r_sprx} - c_speed);
        w_ny = r_dir_y ? ({r_spry[CORDW-1], r_spry} + c_speed)
                       : ({r_spry[CORDW-1], r_spry} - c_speed);
    end

    // Frame divider, update sequencing and edge bounce handling.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_sprx     <= c_x_init;
            r_spry     <= c_y_init;
            r_dir_x    <= 1'b1;
            r_dir_y    <= 1'b1;
            r_bounce_x <= 1'b0;
            r_bounce_y <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // Bounce flags are single-cycle pulses.
            r_bounce_x <= 1'b0;
            r_bounce_y <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A paused frame is neither counted nor acted upon.
                    if (frame && !pause) begin
                        if (r_count == c_div_last) begin
                            r_count <= '0;
                            r_state <= MOVE_X;
                            r_busy  <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                MOVE_X: begin
                    // Landing exactly on a limit counts as a bounce.
                    if (r_dir_x && (w_nx >= c_xmax)) begin
                        r_sprx     <= c_xmax[CORDW-1:0];
                        r_dir_x    <= 1'b0;
                        r_bounce_x <= 1'b1;
                    end else if (!r_dir_x && (w_nx <= c_zero)) begin
                        r_sprx     <= '0;
                        r_dir_x    <= 1'b1;
                        r_bounce_x <= 1'b1;
                    end else begin
                        r_sprx <= w_nx[CORDW-1:0];
                    end
                    r_state <= MOVE_Y;
                end
                MOVE_Y: begin
                    if (r_dir_y && (w_ny >= c_ymax)) begin
                        r_spry     <= c_ymax[CORDW-1:0];
                        r_dir_y    <= 1'b0;
                        r_bounce_y <= 1'b1;
                    end else if (!r_dir_y && (w_ny <= c_zero)) begin
                        r_spry     <= '0;
                        r_dir_y    <= 1'b1;
                        r_bounce_y <= 1'b1;
                    end else begin
                        r_spry <= w_ny[CORDW-1:0];
                    end
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sprx     = r_sprx;
    assign spry     = r_spry;
    assign dir_x    = r_dir_x;
    assign dir_y    = r_dir_y;
    assign bounce_x = r_bounce_x;
    assign bounce_y = r_bounce_y;
    assign busy     = r_busy;

endmodule
`default_nettype wire
